prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/prog_ram.sv | 32 +++
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module : prog_loader_pkg
// Brief  : Shared sizing defaults and FSM encoding for the program loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_FILL = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // States in which the byte stream is consumed.
  function automatic logic takes_bytes(input state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_ram.sv
// ============================================================================
// Module : prog_ram
// Brief  : Instruction store, one synchronous write port, one async read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module : prog_loader
// Brief  : Loads a LEN/data/CHK byte frame into the instruction store and
//          releases the CPU only after a good checksum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          START,
  input  logic          IN_VALID,
  input  logic [DW-1:0] IN_DATA,
  output logic          IN_READY,
  input  logic [AW-1:0] Address,
  output logic [DW-1:0] Order,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERR
);

  localparam logic [DW-1:0] c_DEPTH_W = DW'(DEPTH);
  localparam logic [AW:0]   c_DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_LAST    = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] sum_q, sum_d;

  logic          w_fire;
  logic          w_we;
  logic [DW-1:0] w_wdata;

  assign w_fire = IN_VALID && IN_READY;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    sum_d   = sum_q;
    w_we    = 1'b0;
    w_wdata = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          state_d = S_LEN;
          ptr_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN: begin
        if (w_fire) begin
          if ((IN_DATA == '0) || (IN_DATA > c_DEPTH_W)) begin
            state_d = S_ERR;
          end else begin
            len_d   = IN_DATA[AW:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_fire) begin
          w_we    = 1'b1;
          w_wdata = IN_DATA;
          ptr_d   = ptr_q + 1'b1;
          sum_d   = sum_q + IN_DATA;
          if (({1'b0, ptr_q} + 1'b1) == len_q) begin
            state_d = (len_q == c_DEPTH_L) ? S_CHK : S_FILL;
          end
        end
      end
      S_FILL: begin
        w_we  = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == c_LAST) begin
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (w_fire) begin
          state_d = (IN_DATA == sum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      IN_READY <= 1'b0;
      CPU_HOLD <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      IN_READY <= takes_bytes(state_d);
      CPU_HOLD <= (state_d != S_DONE);
      DONE     <= (state_d == S_DONE);
      ERR      <= (state_d == S_ERR);
    end
  end

  prog_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (w_we && !CLR),
    .waddr_i (ptr_q),
    .wdata_i (w_wdata),
    .raddr_i (Address),
    .rdata_o (Order)
  );

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module : tb_prog_loader
// Brief  : Randomised self-checking bench for prog_loader against a frame model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY;
  logic [3:0] Address = 4'h0;
  logic [7:0] Order;
  logic       CPU_HOLD;
  logic       DONE;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  logic [7:0] fdata   [16];
  logic [7:0] exp_mem [16];
  logic       exp_done = 1'b0;
  logic       exp_err  = 1'b0;

  always #5 CLK = ~CLK;

  prog_loader dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .START    (START),
    .IN_VALID (IN_VALID),
    .IN_DATA  (IN_DATA),
    .IN_READY (IN_READY),
    .Address  (Address),
    .Order    (Order),
    .CPU_HOLD (CPU_HOLD),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Frame-level reference: outcome of a whole frame from its contents alone.
  task automatic model_frame(input int len, input logic [7:0] chk);
    int s;
    if (len < 1 || len > 16) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        if (i < len) begin
          exp_mem[i] = fdata[i];
          s = s + int'(fdata[i]);
        end else begin
          exp_mem[i] = 8'h00;
        end
      end
      exp_done = (chk == 8'(s % 256));
      exp_err  = !exp_done;
    end
  endtask

  task automatic check_all(input string name);
    checks++;
    if (DONE !== exp_done) begin
      errors++; $display("FAIL %s DONE: got %b expected %b", name, DONE, exp_done);
    end
    checks++;
    if (ERR !== exp_err) begin
      errors++; $display("FAIL %s ERR: got %b expected %b", name, ERR, exp_err);
    end
    checks++;
    if (CPU_HOLD !== !exp_done) begin
      errors++; $display("FAIL %s CPU_HOLD: got %b expected %b", name, CPU_HOLD, !exp_done);
    end
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++; $display("FAIL %s IN_READY: got %b expected 0", name, IN_READY);
    end
    for (int a = 0; a < 16; a++) begin
      Address = 4'(a);
      #0.2;
      checks++;
      if (Order !== exp_mem[a]) begin
        errors++; $display("FAIL %s Order[%0d]: got %h expected %h", name, a, Order, exp_mem[a]);
      end
    end
  endtask

  // Presents one byte; returns the number of cycles spent waiting for IN_READY.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit start_ok,
                           output int waited);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
        START    = start_ok && ($urandom_range(0, 1) == 1);
        @(posedge CLK); #1;
        START = 1'b0;
      end
    end
    IN_VALID = 1'b1;
    IN_DATA  = b;
    n = 0;
    while (!IN_READY && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: IN_READY stayed %b, expected 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    waited = n;
  endtask

  task automatic run_frame(input string name, input int len, input logic [7:0] chk,
                           input bit gaps, output int fill_n);
    int n;
    fill_n = 0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    send_byte(8'(len), gaps, 1'b0, n);
    if (len < 1 || len > 16) begin
      checks++;
      if (ERR !== 1'b1) begin
        errors++; $display("FAIL %s bad_len ERR: got %b expected 1", name, ERR);
      end
    end else begin
      for (int i = 0; i < len; i++) send_byte(fdata[i], gaps, gaps, n);
      send_byte(chk, gaps, 1'b0, fill_n);
    end
    model_frame(len, chk);
    check_all(name);
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;
    checks++;
    if ({IN_READY, CPU_HOLD, DONE, ERR} !== 4'b0100) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0100", {IN_READY, CPU_HOLD, DONE, ERR});
    end
  endtask

  task automatic test_full_load();
    int f;
    for (int i = 0; i < 16; i++) fdata[i] = 8'(i);
    run_frame("full_load", 16, 8'h78, 1'b0, f);
    Address = 4'd5;
    #0.2;
    checks++;
    if (Order !== 8'h05) begin
      errors++; $display("FAIL full_load addr5: got %h expected 05", Order);
    end
  endtask

  task automatic test_short_fill();
    int f;
    fdata[0] = 8'hB1; fdata[1] = 8'h01; fdata[2] = 8'hF0;
    run_frame("short_fill", 3, 8'hA2, 1'b0, f);
    checks++;
    if (f != 13) begin
      errors++; $display("FAIL short_fill fill_cycles: got %0d expected 13", f);
    end
  endtask

  task automatic test_bad_chk();
    int f;
    fdata[0] = 8'h11; fdata[1] = 8'h22;
    run_frame("bad_chk", 2, 8'h34, 1'b0, f);
  endtask

  task automatic test_bad_len();
    int f;
    run_frame("bad_len_00", 0, 8'h00, 1'b0, f);
    run_frame("bad_len_11", 17, 8'h00, 1'b0, f);
  endtask

  task automatic test_reset_midload();
    int n;
    int f;
    for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    send_byte(8'd8, 1'b0, 1'b0, n);
    send_byte(fdata[0], 1'b0, 1'b0, n);
    send_byte(fdata[1], 1'b0, 1'b0, n);
    exp_mem[0] = fdata[0];
    exp_mem[1] = fdata[1];
    // A byte on the reset edge must not land in memory.
    CLR = 1'b1; IN_VALID = 1'b1; IN_DATA = ~exp_mem[2];
    @(posedge CLK); #1;
    CLR = 1'b0; IN_VALID = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
    check_all("reset_midload");
    for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom);
    run_frame("after_reset", 16, 8'(fdata.sum() with (int'(item))), 1'b0, f);
  endtask

  task automatic test_clr_priority();
    CLR = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0; START = 1'b0;
    @(posedge CLK); #1;
    exp_done = 1'b0; exp_err = 1'b0;
    check_all("clr_priority");
  endtask

  task automatic test_back_to_back();
    int len;
    int f;
    logic [7:0] chk;
    for (int k = 0; k < 8; k++) begin
      len = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 17 + int'($urandom_range(0, 200)))
                                       : int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom);
      chk = 8'(fdata.sum() with ((item.index < len) ? int'(item) : 0));
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_frame("random_nogap", len, chk, 1'b0, f);
      run_frame("random_gaps", len, chk, 1'b1, f);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    test_reset();
    test_full_load();
    test_short_fill();
    test_bad_chk();
    test_bad_len();
    test_reset_midload();
    test_clr_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
